// File: rtl/lsu.sv
// Load/store unit: turns the ALU result into a single outstanding request/acknowledge
// data-memory access, returns sign/zero-extended load data and stalls the pipeline meanwhile.
module lsu #(
    parameter int WORD_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [5:0]              ls_op,
    input  logic [WORD_WIDTH-1:0]   ex_addr,
    input  logic [WORD_WIDTH-1:0]   st_data,
    input  logic [4:0]              ex_rd,
    output logic                    stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [3:0]              mem_be,
    output logic [WORD_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    input  logic [WORD_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ack,
    output logic                    done,
    output logic                    wb_we,
    output logic [4:0]              wb_rd,
    output logic [WORD_WIDTH-1:0]   wb_data,
    output logic                    err
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [3:0]              mem_be_q, mem_be_d;
    logic [WORD_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    done_q, done_d;
    logic                    wb_we_q, wb_we_d;
    logic [4:0]              wb_rd_q, wb_rd_d;
    logic [WORD_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    err_q, err_d;
    logic                    load_q, load_d;
    logic                    byte_q, byte_d;
    logic                    sext_q, sext_d;
    logic [1:0]              lane_q, lane_d;
    logic [4:0]              rd_q, rd_d;

    logic is_lw, is_lb, is_lbu, is_sw, is_sb;
    logic is_mem, is_word, aligned, accept, misalign, timeout_hit;
    logic [7:0] rd_byte;
    logic [WORD_WIDTH-1:0] load_data;
    logic [7:0] lane_bytes [4];

    always_comb begin
        is_lw    = (ls_op == OP_LW);
        is_lb    = (ls_op == OP_LB);
        is_lbu   = (ls_op == OP_LBU);
        is_sw    = (ls_op == OP_SW);
        is_sb    = (ls_op == OP_SB);
        is_mem   = is_lw | is_lb | is_lbu | is_sw | is_sb;
        is_word  = is_lw | is_sw;
        aligned  = ~is_word | (ex_addr[1:0] == 2'b00);
        accept   = (state_q == IDLE) & ex_valid & is_mem & aligned;
        misalign = (state_q == IDLE) & ex_valid & is_word & ~aligned;
        timeout_hit = (state_q == BUSY) & ~mem_ack & (cnt_q == CNT_W'(TIMEOUT - 1));
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_bytes[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rd_byte = lane_bytes[lane_q];
        if (!byte_q)
            load_data = mem_rdata;
        else if (sext_q)
            load_data = {{(WORD_WIDTH-8){rd_byte[7]}}, rd_byte};
        else
            load_data = {{(WORD_WIDTH-8){1'b0}}, rd_byte};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = BUSY;
            BUSY: if (mem_ack || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of every registered output plus the combinational stall
    always_comb begin
        stall       = accept | ((state_q == BUSY) & ~mem_ack & ~timeout_hit);
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;
        load_d      = load_q;
        byte_d      = byte_q;
        sext_d      = sext_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_sw | is_sb;
                    mem_be_d    = is_word ? 4'b1111 : (4'b0001 << ex_addr[1:0]);
                    mem_addr_d  = {ex_addr[WORD_WIDTH-1:2], 2'b00};
                    mem_wdata_d = is_sb ? {(WORD_WIDTH/8){st_data[7:0]}} : st_data;
                    load_d      = is_lw | is_lb | is_lbu;
                    byte_d      = ~is_word;
                    sext_d      = is_lb;
                    lane_d      = ex_addr[1:0];
                    rd_d        = ex_rd;
                end else if (misalign) begin
                    err_d = 1'b1;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    // Ack beats the timeout when both land in the same cycle
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (load_q) begin
                        wb_we_d   = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = load_data;
                    end
                end else if (timeout_hit) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
            byte_q      <= 1'b0;
            sext_q      <= 1'b0;
            lane_q      <= 2'b00;
            rd_q        <= 5'd0;
        end else begin
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
            load_q      <= load_d;
            byte_q      <= byte_d;
            sext_q      <= sext_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random transactions checked
// against a transaction-level model of the load/store rules.
module tb_lsu;

    localparam int TIMEOUT = 16;
    localparam logic [5:0] LW = 6'b100011, LB = 6'b100000, LBU = 6'b100100,
                           SW = 6'b101011, SB = 6'b101000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [5:0]  ls_op;
    logic [31:0] ex_addr, st_data;
    logic [4:0]  ex_rd;
    logic        stall, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, done, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int txn_id   = 0;

    lsu #(.WORD_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ls_op(ls_op), .ex_addr(ex_addr),
        .st_data(st_data), .ex_rd(ex_rd), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .done(done), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_mem_op(input logic [5:0] op);
        return op == LW || op == LB || op == LBU || op == SW || op == SB;
    endfunction

    function automatic bit is_aligned(input logic [5:0] op, input logic [31:0] addr);
        if (op == LW || op == SW) return (addr % 4) == 0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] b;
        if (op == LW) return rdata;
        b = (rdata >> (8 * (addr % 4))) & 32'hFF;
        if (op == LB && b >= 32'd128) return b | 32'hFFFF_FF00;
        return b;
    endfunction

    // One instruction presented by EX; lat = ack cycle index in BUSY (>= TIMEOUT means never)
    task automatic do_access(input bit valid, input logic [5:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rd, input int lat,
                             input logic [31:0] rdata);
        bit          go, mis, is_load, is_store, acked;
        logic [31:0] exp_be, exp_wdata, exp_wb;
        int          w;
        txn_id++;
        go       = valid && is_mem_op(op) && is_aligned(op, addr);
        mis      = valid && is_mem_op(op) && !is_aligned(op, addr);
        is_load  = op == LW || op == LB || op == LBU;
        is_store = op == SW || op == SB;
        exp_be    = (op == SB) ? (32'd1 << (addr % 4)) : 32'hF;
        exp_wdata = (op == SB) ? (data & 32'hFF) * 32'h0101_0101 : data;
        exp_wb    = model_load(op, addr, rdata);
        $display("txn %0d valid=%0d op=%b addr=%h data=%h rd=%0d lat=%0d rdata=%h",
                 txn_id, valid, op, addr, data, rd, lat, rdata);

        ex_valid = valid; ls_op = op; ex_addr = addr; st_data = data; ex_rd = rd;
        mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        check("stall_accept", stall, go);
        tick();
        if (!go) begin
            ex_valid = 1'b0;
            #1;
            check("err_idle", err, mis);
            check("req_idle", mem_req, 1'b0);
            check("done_idle", done, 1'b0);
            check("stall_idle", stall, 1'b0);
            return;
        end
        // Upstream holds the instruction while BUSY; the unit must ignore it
        acked = 1'b0;
        for (w = 0; w < TIMEOUT; w++) begin
            check("req_busy", mem_req, 1'b1);
            check("we_busy", mem_we, is_store);
            check("addr_busy", mem_addr, addr & 32'hFFFF_FFFC);
            if (op != LB && op != LBU) check("be_busy", mem_be, exp_be);
            if (is_store) check("wdata_busy", mem_wdata, exp_wdata);
            check("pulses_busy", {done, wb_we, err}, 3'b000);
            if (w == lat) begin
                mem_ack = 1'b1; mem_rdata = rdata; acked = 1'b1;
            end else begin
                mem_rdata = $urandom;
            end
            #1;
            check("stall_busy", stall, !(acked || w == TIMEOUT - 1));
            tick();
            mem_ack = 1'b0;
            if (acked || w == TIMEOUT - 1) break;
        end
        ex_valid = 1'b0;
        #1;
        check("req_end", mem_req, 1'b0);
        check("done_end", done, acked);
        check("wbwe_end", wb_we, acked && is_load);
        check("err_end", err, !acked);
        if (acked && is_load) begin
            check("wb_rd", wb_rd, rd);
            check("wb_data", wb_data, exp_wb);
        end
    endtask

    task automatic reset_mid_access();
        txn_id++;
        $display("txn %0d reset while BUSY, then late ack", txn_id);
        ex_valid = 1'b1; ls_op = LW; ex_addr = 32'h0000_0040; ex_rd = 5'd3; mem_ack = 1'b0;
        tick();
        ex_valid = 1'b0;
        check("rst_req_before", mem_req, 1'b1);
        rst = 1'b1;
        tick();
        check("rst_req_after", mem_req, 1'b0);
        check("rst_pulses", {done, wb_we, err}, 3'b000);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check("rst_stall", stall, 1'b0);
        tick();
        mem_ack = 1'b0;
        check("late_ack_req", mem_req, 1'b0);
        check("late_ack_pulses", {done, wb_we, err}, 3'b000);
    endtask

    initial begin
        logic [5:0] ops [8];
        int k, lat;
        logic [31:0] a;
        ops[0] = LW; ops[1] = LB; ops[2] = LBU; ops[3] = SW; ops[4] = SB;
        ops[5] = 6'b000000; ops[6] = 6'b100001; ops[7] = 6'b001000;

        rst = 1'b1; ex_valid = 1'b0; ls_op = 6'd0; ex_addr = '0; st_data = '0; ex_rd = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) tick();
        check("rst_outputs", {mem_req, mem_we, mem_be, done, wb_we, err, stall}, 10'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wb", {27'd0, wb_rd} | wb_data, 32'd0);
        rst = 1'b0;
        tick();

        do_access(1, LW,  32'h0000_0100, 32'h0,          5'd8,  0,           32'hDEAD_BEEF);
        do_access(1, SB,  32'h0000_0203, 32'h0000_00A5,  5'd0,  3,           32'h0);
        do_access(1, LB,  32'h0000_0002, 32'h0,          5'd4,  1,           32'h12F0_3456);
        do_access(1, LBU, 32'h0000_0002, 32'h0,          5'd5,  2,           32'h12F0_3456);
        do_access(1, LW,  32'h0000_0102, 32'h0,          5'd9,  0,           32'h0);
        do_access(1, LW,  32'h0000_0104, 32'h0,          5'd9,  TIMEOUT + 4, 32'h0);
        do_access(1, LW,  32'h0000_0108, 32'h0,          5'd10, 1,           32'h0BAD_F00D);
        do_access(1, SW,  32'h0000_0300, 32'h1234_5678,  5'd0,  TIMEOUT - 1, 32'h0);
        reset_mid_access();
        do_access(1, LB,  32'h0000_0041, 32'h0,          5'd11, 0,           32'h0000_8000);

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 7);
            a = $urandom;
            if ((ops[k] == LW || ops[k] == SW) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case ($urandom_range(0, 5))
                0:       lat = TIMEOUT - 1;
                1:       lat = TIMEOUT + 2;
                default: lat = $urandom_range(0, 6);
            endcase
            do_access($urandom_range(0, 9) != 0, ops[k], a, $urandom, 5'($urandom), lat, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
